iter_compare: RTL and testbench
===============================

// Module: iter_compare
// PURPOSE
//  Parametrised, multi-cycle successor of the single-cycle compare unit.
//  Evaluates one of eight relations between two WIDTH-bit operands via a chunked a-b subtraction, CHUNK bits per cycle, LSB first.
//  Sits beside the EXU branch path for wide/low-area configs; valid/ready on both sides.
// PARAMETERS
//  WIDTH  32  operand width in bits; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  CHUNK  8   bits subtracted per cycle; NCYC = WIDTH/CHUNK iterations
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid_i   in   1      operands/fn offered
//  in_ready_o   out  1      unit can accept
//  cmp_a_i      in   WIDTH  operand a
//  cmp_b_i      in   WIDTH  operand b
//  cmp_fn_i     in   3      relation select (encoding below)
//  out_valid_o  out  1      result valid, held until taken
//  out_ready_i  in   1      consumer accepts result
//  cmp_o        out  1      relation result
//  flags_o      out  4      {Z,N,V,C} of a-b; present only with CMP_FLAGS_EN
// BEHAVIOUR
//  fn: 000 EQ=Z; 001 NE=~Z; 010 GE signed=(N==V); 011 LT signed=(N!=V);
//      100 GTU=C&~Z; 101 LTU=~C; 110 GEU=C; 111 OVF=V.
//  C = carry-out of a+~b+1 (1 means no borrow); N = diff[WIDTH-1];
//  V = (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]); Z = diff==0 over all chunks.
//  FSM: IDLE -> BUSY on in_valid_i&in_ready_o; a, b, fn latched; carry=1, zacc=1, cnt=0.
//   BUSY: per cycle, chunk cnt: {carry,d}=a_c+~b_c+carry; zacc&=(d==0); cnt++.
//   On cnt==NCYC-1: capture N/V from last chunk, -> DONE.
//   DONE: out_valid_o=1, cmp_o/flags_o stable; leave on out_ready_i.
//  Latency: accept at edge t -> out_valid_o high after edge t+NCYC (NCYC=1: next cycle).
//  in_ready_o = (state==IDLE) | (state==DONE & out_ready_i); back-to-back
//   accept in DONE goes straight to BUSY; no bubble on input side.
//  in_valid_i while BUSY or while DONE & ~out_ready_i: ignored, operands not sampled.
//  Inputs may change after acceptance without effect.
//  Reset (any state, incl. mid-BUSY): state=IDLE, out_valid_o=0, cmp_o=0, flags_o=0,
//   cnt=0; in-flight op discarded, no result emitted; in_ready_o=0 while rst high.
//  cmp_o/flags_o registered; unchanged while out_valid_o&~out_ready_i.
// CONFIGURATION
//  CMP_FLAGS_EN defined: flags_o port exists, driven from the DONE-state flag regs.
//  Undefined: no flags_o port, no flag regs beyond those cmp_o needs; cmp_o identical.
// STRUCTURE
//  Package cmp_pkg: fn encodings (CMP_EQ..CMP_OVF), FSM state enum (IDLE/BUSY/DONE),
//   flag-vector bit indices.
//  Sub-module cmp_chunk_sub (comb, CHUNK wide): a_c, b_c, cin -> d, cout, d_msb.
//  Top keeps operand regs, counter, carry/zacc, FSM and relation mux.
// TESTING  (WIDTH=32, CHUNK=8 unless noted)
//  a=0x0000_1234,b=0x0000_1234,fn=000 -> cmp_o=1 exactly 4 cycles after accept; fn=001 -> 0.
//  a=0xFFFF_FFFF,b=0x0000_0001: fn=011 -> 1 (-1<1); fn=101 -> 0; fn=100 -> 1.
//  a=0x8000_0000,b=0x0000_0001,fn=111 -> cmp_o=1 (V); with CMP_FLAGS_EN flags_o=4'b0011.
//  out_ready_i low 5 cycles after result: cmp_o held, in_ready_o=0, new in_valid_i ignored;
//   then out_ready_i&in_valid_i same cycle -> next op accepted, result 4 cycles later.
//  rst pulsed in 2nd BUSY cycle -> out_valid_o never rises; next op (a=5,b=3,fn=010) -> 1.
//  WIDTH=8,CHUNK=8: a=0x7F,b=0x80,fn=010 -> cmp_o=1 one cycle after accept; fn=110 -> 0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for iter_compare: relation encodings, FSM states, flag bit
// positions and the relation-select helper.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'b000,
        CMP_NE  = 3'b001,
        CMP_GE  = 3'b010,
        CMP_LT  = 3'b011,
        CMP_GTU = 3'b100,
        CMP_LTU = 3'b101,
        CMP_GEU = 3'b110,
        CMP_OVF = 3'b111
    } cmp_fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Bit positions inside the {Z,N,V,C} flag vector
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

    function automatic logic cmp_eval(input cmp_fn_e fn, input logic z, input logic n,
                                      input logic v, input logic c);
        logic r;
        r = 1'b0;
        case (fn)
            CMP_EQ:  r = z;
            CMP_NE:  r = ~z;
            CMP_GE:  r = (n == v);
            CMP_LT:  r = (n != v);
            CMP_GTU: r = c & ~z;
            CMP_LTU: r = ~c;
            CMP_GEU: r = c;
            CMP_OVF: r = v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_chunk_sub.sv
// One CHUNK-wide slice of the a-b subtraction: {cout,d} = a_c + ~b_c + cin.
module cmp_chunk_sub #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             cin,
    output logic [CHUNK-1:0] d,
    output logic             cout,
    output logic             d_msb
);

    always_comb begin
        {cout, d} = {1'b0, a_c} + {1'b0, ~b_c} + {{CHUNK{1'b0}}, cin};
        d_msb     = d[CHUNK-1];
    end

endmodule

// File: rtl/iter_compare.sv
// Multi-cycle relation unit: a-b evaluated CHUNK bits per cycle, LSB first.
// Optional flags_o port enabled by defining CMP_FLAGS_EN.
module iter_compare
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] cmp_a_i,
    input  logic [WIDTH-1:0] cmp_b_i,
    input  logic [2:0]       cmp_fn_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             cmp_o
`ifdef CMP_FLAGS_EN
    ,
    output logic [3:0]       flags_o
`endif
);

    localparam int unsigned NCYC  = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCYC - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("iter_compare: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    cmp_fn_e          fn_q;
    logic             a_msb_q, b_msb_q;
    logic             carry_q, zacc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CHUNK-1:0] d;
    logic             cout, d_msb;
    logic             accept, last, z_fin, v_fin;

    // Operands are shifted right each cycle so the slice always sees the low chunk
    cmp_chunk_sub #(.CHUNK(CHUNK)) u_chunk (
        .a_c   (a_q[CHUNK-1:0]),
        .b_c   (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .d     (d),
        .cout  (cout),
        .d_msb (d_msb)
    );

    assign in_ready_o  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
    assign out_valid_o = (state_q == DONE);
    assign accept      = in_valid_i & in_ready_o;
    assign last        = (state_q == BUSY) && (cnt_q == LAST);
    assign z_fin       = zacc_q & (d == '0);
    assign v_fin       = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE: begin
                if (accept)           state_d = BUSY;
                else if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b1;
            zacc_q  <= 1'b1;
            cmp_o   <= 1'b0;
`ifdef CMP_FLAGS_EN
            flags_o <= '0;
`endif
        end else if (accept) begin
            a_q     <= cmp_a_i;
            b_q     <= cmp_b_i;
            fn_q    <= cmp_fn_e'(cmp_fn_i);
            a_msb_q <= cmp_a_i[WIDTH-1];
            b_msb_q <= cmp_b_i[WIDTH-1];
            carry_q <= 1'b1;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
        end else if (state_q == BUSY) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= cout;
            zacc_q  <= z_fin;
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                cmp_o <= cmp_eval(fn_q, z_fin, d_msb, v_fin, cout);
`ifdef CMP_FLAGS_EN
                flags_o[FLAG_Z] <= z_fin;
                flags_o[FLAG_N] <= d_msb;
                flags_o[FLAG_V] <= v_fin;
                flags_o[FLAG_C] <= cout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_iter_compare.sv
// Self-checking bench for iter_compare (32/8 instance plus an 8/8 instance),
// compared against an arithmetic reference model.
module tb_iter_compare;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, cmp_res;
    logic [31:0] cmp_a, cmp_b;
    logic [2:0]  cmp_fn;
`ifdef CMP_FLAGS_EN
    logic [3:0]  flags;
    logic [3:0]  flags8;
`endif

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cmp_res8;
    logic [7:0]  cmp_a8, cmp_b8;
    logic [2:0]  cmp_fn8;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    iter_compare #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .cmp_a_i     (cmp_a),
        .cmp_b_i     (cmp_b),
        .cmp_fn_i    (cmp_fn),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .cmp_o       (cmp_res)
`ifdef CMP_FLAGS_EN
        ,
        .flags_o     (flags)
`endif
    );

    iter_compare #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid8),
        .in_ready_o  (in_ready8),
        .cmp_a_i     (cmp_a8),
        .cmp_b_i     (cmp_b8),
        .cmp_fn_i    (cmp_fn8),
        .out_valid_o (out_valid8),
        .out_ready_i (out_ready8),
        .cmp_o       (cmp_res8)
`ifdef CMP_FLAGS_EN
        ,
        .flags_o     (flags8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {cmp, Z, N, V, C} derived from plain integer arithmetic
    function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] fn);
        longint sd;
        logic [31:0] diff;
        logic z, n, v, c, r;
        diff = a - b;
        sd   = longint'($signed(a)) - longint'($signed(b));
        z    = (a == b);
        n    = diff[31];
        v    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        c    = (a >= b);
        case (fn)
            3'd0: r = (a == b);
            3'd1: r = (a != b);
            3'd2: r = !($signed(a) < $signed(b));
            3'd3: r = ($signed(a) < $signed(b));
            3'd4: r = (a > b);
            3'd5: r = (a < b);
            3'd6: r = (a >= b);
            default: r = v;
        endcase
        return {r, z, n, v, c};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] fn);
        int unsigned w;
        cmp_a    = a;
        cmp_b    = b;
        cmp_fn   = fn;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w == 20) check("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        // scribble the inputs afterwards; they must not affect the running op
        in_valid = 1'($urandom_range(0, 1));
        cmp_a    = $urandom;
        cmp_b    = $urandom;
        cmp_fn   = 3'($urandom);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] fn);
        int unsigned cyc;
        logic [4:0] exp;
        exp = model(a, b, fn);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd4);
        check({tag, "_cmp"}, 32'(cmp_res), 32'(exp[4]));
`ifdef CMP_FLAGS_EN
        check({tag, "_flags"}, 32'(flags), 32'(exp[3:0]));
`endif
    endtask

    task automatic take_result(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_taken"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] fn);
        start_op(a, b, fn);
        wait_result(tag, a, b, fn);
        take_result(tag);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] fn, input logic exp);
        int unsigned cyc;
        cmp_a8    = a;
        cmp_b8    = b;
        cmp_fn8   = fn;
        in_valid8 = 1'b1;
        check({tag, "_ready"}, 32'(in_ready8), 32'd1);
        tick();
        in_valid8 = 1'b0;
        cmp_a8    = 8'($urandom);
        cyc = 0;
        while (!out_valid8 && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd1);
        check({tag, "_cmp"}, 32'(cmp_res8), 32'(exp));
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        logic        held;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        cmp_a = '0; cmp_b = '0; cmp_fn = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        cmp_a8 = '0; cmp_b8 = '0; cmp_fn8 = '0;
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cmp", 32'(cmp_res), 32'd0);
`ifdef CMP_FLAGS_EN
        check("rst_flags", 32'(flags), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        run_op("eq",  32'h0000_1234, 32'h0000_1234, 3'b000);
        run_op("ne",  32'h0000_1234, 32'h0000_1234, 3'b001);
        run_op("lt",  32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
        run_op("ltu", 32'hFFFF_FFFF, 32'h0000_0001, 3'b101);
        run_op("gtu", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        run_op("ovf", 32'h8000_0000, 32'h0000_0001, 3'b111);

        // result held while the consumer stalls; new offers ignored
        start_op(32'h0000_1234, 32'h0000_1234, 3'b000);
        wait_result("hold", 32'h0000_1234, 32'h0000_1234, 3'b000);
        held = cmp_res;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            cmp_a    = $urandom;
            cmp_b    = $urandom;
            cmp_fn   = 3'($urandom);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_cmp", 32'(cmp_res), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        cmp_a     = 32'hFFFF_FFFF;
        cmp_b     = 32'h0000_0001;
        cmp_fn    = 3'b011;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cmp_a     = $urandom;
        check("b2b_busy", 32'(out_valid), 32'd0);
        wait_result("b2b", 32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
        take_result("b2b");

        // reset in the second BUSY cycle discards the operation
        start_op(32'h0000_0010, 32'h0000_0020, 3'b101);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_cmp", 32'(cmp_res), 32'd0);
        rst = 1'b0;
        held = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) held = 1'b1;
        end
        check("midrst_no_result", 32'(held), 32'd0);
        run_op("after_rst", 32'd5, 32'd3, 3'b010);

        // randomized operations, biased toward equal operands and sign-boundary values
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 3'($urandom);
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: ra = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
                2: rb = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op("rand", ra, rb, rf);
        end

        run8("w8_ge",  8'h7F, 8'h80, 3'b010, 1'b1);
        run8("w8_geu", 8'h7F, 8'h80, 3'b110, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
